// File: rtl/seg_fade_decoder.sv
// seg_fade_decoder
//   Receive-side monitor for a faded 7-segment chaser. It samples the seven
//   segment pins over fixed windows of 2**WINDOW_WIDTH cycles and counts how
//   many cycles each segment is lit. At the end of each window it picks the
//   brightest segment and maps that segment back to the 3-bit chase state. It
//   then reports the chase direction, single-step advances and out-of-sequence
//   jumps.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high
//   seg_in[6:0]  segment pins a..g (bit0 = seg0), asynchronous to clk
//   window_done  1-cycle pulse when a new window result is presented
//   lead_seg     index 0..6 of the brightest segment in the last window
//   lead_duty    lit-cycle count of lead_seg
//   state        decoded chase state
//   state_valid  decoded state is locked
//   direction    1 = state incrementing, 0 = decrementing
//   step         1-cycle pulse: state advanced by +/-1
//   sync_err     1-cycle pulse: state jumped by something other than +/-1
//
// Lock FSM
//   state    | meaning
//   UNLOCKED | no trusted chase state; the next valid window acquires one
//   LOCKED   | state tracks the chase; changes are classified as step/sync_err
module seg_fade_decoder #(
  parameter int WINDOW_WIDTH = 8,
  parameter int MIN_DUTY     = 128,
  parameter int COMMON_ANODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  output logic                  window_done,
  output logic [2:0]            lead_seg,
  output logic [WINDOW_WIDTH:0] lead_duty,
  output logic [2:0]            state,
  output logic                  state_valid,
  output logic                  direction,
  output logic                  step,
  output logic                  sync_err
);

  localparam int            CW      = WINDOW_WIDTH + 1;
  localparam logic [CW-1:0] MIN_LIT = CW'(MIN_DUTY);
  localparam logic [6:0]    LIT_XOR = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;

  lock_t                   lock;
  logic [6:0]              sync_a;
  logic [6:0]              sync_b;
  logic [6:0]              lit;
  logic [WINDOW_WIDTH-1:0] win_cnt;
  logic                    win_end;
  logic                    eval_pend;
  logic [CW-1:0]           cnt  [7];
  logic [CW-1:0]           duty [7];
  logic [2:0]              best_idx;
  logic [CW-1:0]           best_duty;
  logic [2:0]              new_state;
  logic [2:0]              delta;

  assign lit         = sync_b ^ LIT_XOR;
  assign win_end     = &win_cnt;
  assign state_valid = (lock == LOCKED);
  // 3-bit subtraction gives the modulo-8 distance, so 7->0 reads as +1
  assign delta       = new_state - state;

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    best_idx  = 3'd0;
    best_duty = duty[0];
    for (int i = 1; i < 7; i++) begin
      if (duty[i] > best_duty) begin
        best_idx  = 3'(i);
        best_duty = duty[i];
      end
    end
  end

  // Segment 6 is lit for both chase states 2 and 6; the previous locked
  // state tells us which half of the chase we are in.
  always_comb begin
    new_state = 3'd0;
    case (best_idx)
      3'd0:    new_state = 3'd0;
      3'd1:    new_state = 3'd1;
      3'd2:    new_state = 3'd5;
      3'd3:    new_state = 3'd4;
      3'd4:    new_state = 3'd3;
      3'd5:    new_state = 3'd7;
      3'd6:    new_state = (lock == LOCKED && state >= 3'd5) ? 3'd6 : 3'd2;
      default: new_state = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a      <= '0;
      sync_b      <= '0;
      win_cnt     <= '0;
      eval_pend   <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        cnt[i]  <= '0;
        duty[i] <= '0;
      end
      lock        <= UNLOCKED;
      window_done <= 1'b0;
      lead_seg    <= '0;
      lead_duty   <= '0;
      state       <= '0;
      direction   <= 1'b0;
      step        <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      sync_a    <= seg_in;
      sync_b    <= sync_a;
      win_cnt   <= win_cnt + 1'b1;
      eval_pend <= win_end;

      // The last cycle's sample is folded into the latched duty so every
      // window covers exactly 2**WINDOW_WIDTH samples.
      for (int i = 0; i < 7; i++) begin
        if (win_end) begin
          duty[i] <= cnt[i] + CW'(lit[i]);
          cnt[i]  <= '0;
        end else begin
          cnt[i]  <= cnt[i] + CW'(lit[i]);
        end
      end

      window_done <= eval_pend;
      step        <= 1'b0;
      sync_err    <= 1'b0;

      if (eval_pend) begin
        lead_seg  <= best_idx;
        lead_duty <= best_duty;
        if (best_duty < MIN_LIT) begin
          lock <= UNLOCKED;
        end else if (lock == UNLOCKED) begin
          lock  <= LOCKED;
          state <= new_state;
        end else if (new_state != state) begin
          state <= new_state;
          if (delta == 3'd1) begin
            step      <= 1'b1;
            direction <= 1'b1;
          end else if (delta == 3'd7) begin
            step      <= 1'b1;
            direction <= 1'b0;
          end else begin
            sync_err  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_fade_decoder.sv
// Testbench for seg_fade_decoder. The reference model counts lit samples per
// window from a two-deep pin delay queue. It then applies the chase-state
// rules directly to produce the result expected at each window_done.
module tb_seg_fade_decoder;

  localparam int W    = 8;
  localparam int WLEN = 1 << W;
  localparam int CA   = 1;
  localparam int MIND = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   seg_in = 7'h7F;
  logic         window_done;
  logic [2:0]   lead_seg;
  logic [W:0]   lead_duty;
  logic [2:0]   state;
  logic         state_valid;
  logic         direction;
  logic         step;
  logic         sync_err;

  int errors = 0;
  int checks = 0;

  seg_fade_decoder #(
    .WINDOW_WIDTH(W),
    .MIN_DUTY(MIND),
    .COMMON_ANODE(CA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .window_done(window_done),
    .lead_seg(lead_seg),
    .lead_duty(lead_duty),
    .state(state),
    .state_valid(state_valid),
    .direction(direction),
    .step(step),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [6:0] pinq[$];
  int  mcnt[7];
  int  m_cyc;
  int  e_lead, e_duty, e_state;
  bit  e_valid, e_dir, e_step, e_err;
  int  seg2st[7] = '{0, 1, 5, 4, 3, 7, 2};

  always @(posedge clk) begin : model
    logic [6:0] p;
    int lead, ns, d;
    if (reset) begin
      pinq.delete();
      pinq.push_back(7'h00);
      pinq.push_back(7'h00);
      m_cyc = 0;
      for (int i = 0; i < 7; i++) mcnt[i] = 0;
      e_lead = 0; e_duty = 0; e_state = 0;
      e_valid = 0; e_dir = 0; e_step = 0; e_err = 0;
    end else begin
      p = pinq.pop_front();
      pinq.push_back(seg_in);
      for (int i = 0; i < 7; i++)
        if ((p[i] ^ (CA != 0)) == 1'b1) mcnt[i]++;
      m_cyc++;
      if (m_cyc == WLEN) begin
        lead = 0;
        for (int i = 1; i < 7; i++)
          if (mcnt[i] > mcnt[lead]) lead = i;
        e_lead = lead;
        e_duty = mcnt[lead];
        e_step = 0;
        e_err  = 0;
        if (e_duty < MIND) begin
          e_valid = 0;
        end else begin
          if (lead == 6) ns = (e_valid && e_state >= 5) ? 6 : 2;
          else           ns = seg2st[lead];
          if (!e_valid) begin
            e_state = ns;
            e_valid = 1;
          end else if (ns != e_state) begin
            d = (ns - e_state + 8) % 8;
            if (d == 1)      begin e_step = 1; e_dir = 1; end
            else if (d == 7) begin e_step = 1; e_dir = 0; end
            else             e_err = 1;
            e_state = ns;
          end
        end
        m_cyc = 0;
        for (int i = 0; i < 7; i++) mcnt[i] = 0;
      end
    end
  end

  function automatic logic [19:0] got_vec();
    return {window_done, lead_seg, lead_duty, state, state_valid, direction, step, sync_err};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {1'b1, 3'(e_lead), 9'(e_duty), 3'(e_state), e_valid, e_dir, e_step, e_err};
  endfunction

  // mode 0: hold seg_in; mode 1: lead lit hi%, others lo% at random;
  // mode 2: segments in mask lit for the first hi cycles, others for lo cycles
  task automatic drive(input int mode, input int lead, input int hi, input int lo,
                       input logic [6:0] mask, output bit ok);
    logic [6:0] lit;
    ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (mode != 0) begin
        for (int i = 0; i < 7; i++) begin
          if (mode == 1) lit[i] = ($urandom_range(0, 99) < ((i == lead) ? hi : lo));
          else           lit[i] = (k < (mask[i] ? hi : lo));
        end
        seg_in = (CA != 0) ? ~lit : lit;
      end
      @(posedge clk); #1;
      if (window_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL window_timeout: window_done not seen within 600 cycles");
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seg_in = 7'($urandom);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({window_done, lead_seg, lead_duty, state, state_valid, direction, step, sync_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {window_done, lead_seg, lead_duty, state, state_valid, direction, step, sync_err});
    end
    reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      n = k;
      if (window_done) break;
    end
    checks++;
    if (n != WLEN + 1 || window_done !== 1'b1) begin
      errors++;
      $display("FAIL first_window_latency: got cycle %0d required %0d", n, WLEN + 1);
    end
    if (window_done === 1'b1) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL first_window_result: got %h required %h", got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_static();
    bit ok;
    seg_in = 7'b1111110;
    for (int w = 0; w < 2; w++) begin
      drive(0, 0, 0, 0, 7'h00, ok);
      if (ok) begin
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL static_model w%0d: got %h required %h", w, got_vec(), exp_vec());
        end
        if (w == 1) begin
          checks++;
          if ({lead_seg, lead_duty, state, state_valid, step, sync_err} !== {3'd0, 9'd256, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL static_seg0: got seg=%0d duty=%0d state=%0d valid=%b step=%b err=%b required 0 256 0 1 0 0",
                     lead_seg, lead_duty, state, state_valid, step, sync_err);
          end
        end
      end
    end
  endtask

  task automatic test_forward();
    bit ok;
    int leads[9] = '{0, 1, 6, 4, 3, 2, 6, 5, 0};
    int sts[9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    for (int j = 0; j < 9; j++) begin
      drive(1, leads[j], 92, 35, 7'h00, ok);
      if (ok) begin
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL forward_model j%0d: got %h required %h", j, got_vec(), exp_vec());
        end
        checks++;
        if (state !== 3'(sts[j]) || step !== (j != 0) || sync_err !== 1'b0 ||
            state_valid !== 1'b1 || (j != 0 && direction !== 1'b1)) begin
          errors++;
          $display("FAIL forward_seq j%0d: got state=%0d step=%b err=%b valid=%b dir=%b required state=%0d step=%b err=0 valid=1 dir=1",
                   j, state, step, sync_err, state_valid, direction, sts[j], (j != 0));
        end
      end
    end
  endtask

  task automatic test_backward();
    bit ok;
    int leads[4] = '{5, 6, 2, 3};
    int sts[4]   = '{7, 6, 5, 4};
    for (int j = 0; j < 4; j++) begin
      drive(1, leads[j], 92, 35, 7'h00, ok);
      if (ok) begin
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL backward_model j%0d: got %h required %h", j, got_vec(), exp_vec());
        end
        checks++;
        if (state !== 3'(sts[j]) || step !== 1'b1 || direction !== 1'b0 || sync_err !== 1'b0) begin
          errors++;
          $display("FAIL backward_seq j%0d: got state=%0d step=%b dir=%b err=%b required state=%0d step=1 dir=0 err=0",
                   j, state, step, direction, sync_err, sts[j]);
        end
      end
    end
  endtask

  task automatic test_jump();
    bit ok;
    drive(1, 0, 92, 35, 7'h00, ok);
    if (ok) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL jump_to0_model: got %h required %h", got_vec(), exp_vec());
      end
    end
    drive(1, 3, 92, 35, 7'h00, ok);
    if (ok) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL jump_model: got %h required %h", got_vec(), exp_vec());
      end
      checks++;
      if (state !== 3'd4 || sync_err !== 1'b1 || step !== 1'b0 || direction !== 1'b0) begin
        errors++;
        $display("FAIL jump_0_to_4: got state=%0d err=%b step=%b dir=%b required state=4 err=1 step=0 dir=0",
                 state, sync_err, step, direction);
      end
    end
  endtask

  task automatic test_duty();
    bit ok;
    drive(2, 0, 100, 100, 7'h7F, ok);
    if (ok) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL low_duty_model: got %h required %h", got_vec(), exp_vec());
      end
      checks++;
      if (state_valid !== 1'b0 || lead_duty >= 9'(MIND) || step !== 1'b0 || sync_err !== 1'b0) begin
        errors++;
        $display("FAIL low_duty_unlock: got valid=%b duty=%0d step=%b err=%b required valid=0 duty<%0d step=0 err=0",
                 state_valid, lead_duty, step, sync_err, MIND);
      end
    end
    drive(2, 0, 200, 50, 7'b0000110, ok);
    if (ok) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tie_model: got %h required %h", got_vec(), exp_vec());
      end
      checks++;
      if (lead_seg !== 3'd1 || state_valid !== 1'b1 || state !== 3'd1) begin
        errors++;
        $display("FAIL tie_lowest: got seg=%0d valid=%b state=%0d required seg=1 valid=1 state=1",
                 lead_seg, state_valid, state);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int j = 0; j < 12; j++) begin
      drive(1, $urandom_range(0, 6), $urandom_range(40, 95), $urandom_range(5, 45), 7'h00, ok);
      if (ok) begin
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random_model j%0d: got %h required %h", j, got_vec(), exp_vec());
        end
        @(posedge clk); #1;
        checks++;
        if ({window_done, step, sync_err} !== 3'b000) begin
          errors++;
          $display("FAIL pulse_width j%0d: got done/step/err=%b required 000", j, {window_done, step, sync_err});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_forward();
    test_backward();
    test_jump();
    test_duty();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
